// File: rtl/xlr8_portmux_pcint.sv
// Pad mux with prioritised XB overrides, input synchroniser and sticky pin-change detect.
// Optional per-bit input debounce on the AVR PINx path: define XLR8_PORTMUX_DEBOUNCE_EN.
module xlr8_portmux_pcint #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned NUM_XB          = 2,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [WIDTH-1:0]        port_portx,
    input  logic [WIDTH-1:0]        port_ddrx,
    input  logic [NUM_XB*WIDTH-1:0] xb_ddoe,
    input  logic [NUM_XB*WIDTH-1:0] xb_ddov,
    input  logic [NUM_XB*WIDTH-1:0] xb_pvoe,
    input  logic [NUM_XB*WIDTH-1:0] xb_pvov,
    input  logic                    pcie,
    input  logic [WIDTH-1:0]        pcmsk,
    input  logic                    pcint_clr,
    inout  wire  [WIDTH-1:0]        port_pads,
    output logic [WIDTH-1:0]        port_pinx,
    output logic [WIDTH-1:0]        xb_pinx,
    output logic                    pc_flag,
    output logic [WIDTH-1:0]        pc_bits
);

    localparam int unsigned WU_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {WARMUP, ARMED} state_t;

    logic [WIDTH-1:0] oe_c, dout_c;
    logic [WIDTH-1:0] oe_q, dout_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_last;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] chg_c;
    logic             event_c;
    logic             warmup_c;
    state_t           state_q, state_d;
    logic [WU_W-1:0]  cnt_q, cnt_d;

    // Walk from lowest to highest priority so source 0 lands last and wins.
    always_comb begin
        oe_c   = port_ddrx;
        dout_c = port_portx;
        for (int i = int'(NUM_XB) - 1; i >= 0; i--) begin
            oe_c   = (xb_ddoe[i*WIDTH +: WIDTH] & xb_ddov[i*WIDTH +: WIDTH])
                   | (~xb_ddoe[i*WIDTH +: WIDTH] & oe_c);
            dout_c = (xb_pvoe[i*WIDTH +: WIDTH] & xb_pvov[i*WIDTH +: WIDTH])
                   | (~xb_pvoe[i*WIDTH +: WIDTH] & dout_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            oe_q   <= '0;
            dout_q <= '0;
        end else begin
            oe_q   <= oe_c;
            dout_q <= dout_c;
        end
    end

    for (genvar b = 0; b < int'(WIDTH); b++) begin : g_pad
        assign port_pads[b] = oe_q[b] ? dout_q[b] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= port_pads;
            for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign xb_pinx   = sync_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= WARMUP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Warm-up lets the synchroniser fill before edges are trusted.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        warmup_c = 1'b0;
        case (state_q)
            WARMUP: begin
                warmup_c = 1'b1;
                cnt_d    = cnt_q + WU_W'(1);
                if (cnt_q == WU_W'(SYNC_STAGES)) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                state_d = ARMED;
            end
            default: begin
                state_d = WARMUP;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef XLR8_PORTMUX_DEBOUNCE_EN
    logic [7:0]       db_cnt_q [WIDTH];
    logic [WIDTH-1:0] filt_q;

    // A bit must disagree with filt for DEBOUNCE_CYCLES straight cycles to propagate.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            filt_q <= '0;
            for (int b = 0; b < int'(WIDTH); b++) db_cnt_q[b] <= '0;
        end else if (warmup_c) begin
            filt_q <= sync_last;
            for (int b = 0; b < int'(WIDTH); b++) db_cnt_q[b] <= '0;
        end else begin
            for (int b = 0; b < int'(WIDTH); b++) begin
                if (sync_last[b] == filt_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    filt_q[b]   <= sync_last[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + 8'd1;
                end
            end
        end
    end

    assign filt = filt_q;
`else
    assign filt = sync_last;
`endif

    assign port_pinx = filt;
    assign chg_c     = (filt ^ prev_q) & pcmsk;
    assign event_c   = (state_q == ARMED) && pcie && (|chg_c);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_q <= '0;
        end else begin
            prev_q <= warmup_c ? sync_last : filt;
        end
    end

    // A new event outranks a coincident clear but drops the bits being cleared.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_flag <= 1'b0;
            pc_bits <= '0;
        end else if (event_c) begin
            pc_flag <= 1'b1;
            pc_bits <= pcint_clr ? chg_c : (pc_bits | chg_c);
        end else if (pcint_clr) begin
            pc_flag <= 1'b0;
            pc_bits <= '0;
        end
    end

endmodule

// File: tb/tb_xlr8_portmux_pcint.sv
// Directed bench for xlr8_portmux_pcint with a queued expectation scoreboard.
// Debounce-specific steps build only when XLR8_PORTMUX_DEBOUNCE_EN is defined.
module tb_xlr8_portmux_pcint;

    localparam int W  = 8;
    localparam int NX = 2;
    localparam int SS = 2;
`ifdef XLR8_PORTMUX_DEBOUNCE_EN
    localparam int DB   = 4;
    localparam int FLAT = SS + DB;
`else
    localparam int FLAT = SS;
`endif

    logic            clk = 1'b0;
    logic            rstn;
    logic [W-1:0]    port_portx, port_ddrx;
    logic [NX*W-1:0] xb_ddoe, xb_ddov, xb_pvoe, xb_pvov;
    logic            pcie, pcint_clr;
    logic [W-1:0]    pcmsk;
    wire  [W-1:0]    pads;
    logic [W-1:0]    port_pinx, xb_pinx, pc_bits;
    logic            pc_flag;
    logic [W-1:0]    tb_en, tb_val;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    for (genvar b = 0; b < W; b++) begin : g_drv
        assign pads[b] = tb_en[b] ? tb_val[b] : 1'bz;
    end

    xlr8_portmux_pcint #(
        .WIDTH(W), .NUM_XB(NX), .SYNC_STAGES(SS)
`ifdef XLR8_PORTMUX_DEBOUNCE_EN
        , .DEBOUNCE_CYCLES(DB)
`endif
    ) dut (
        .clk(clk), .rstn(rstn),
        .port_portx(port_portx), .port_ddrx(port_ddrx),
        .xb_ddoe(xb_ddoe), .xb_ddov(xb_ddov), .xb_pvoe(xb_pvoe), .xb_pvov(xb_pvov),
        .pcie(pcie), .pcmsk(pcmsk), .pcint_clr(pcint_clr),
        .port_pads(pads), .port_pinx(port_pinx), .xb_pinx(xb_pinx),
        .pc_flag(pc_flag), .pc_bits(pc_bits)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pad_ones();
        logic [W-1:0] r;
        for (int b = 0; b < W; b++) r[b] = (pads[b] === 1'b1);
        return r;
    endfunction

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic check(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; port_portx = '0; port_ddrx = '0;
        xb_ddoe = '0; xb_ddov = '0; xb_pvoe = '0; xb_pvov = '0;
        pcie = 1'b0; pcmsk = '0; pcint_clr = 1'b0; tb_en = '0; tb_val = '0;

        // Reset state
        expect_val("rst_pads", 32'h0);
        expect_val("rst_xb_pinx", 32'h0);
        expect_val("rst_port_pinx", 32'h0);
        expect_val("rst_pc_flag", 32'h0);
        expect_val("rst_pc_bits", 32'h0);
        tick(); tick();
        check(32'(pad_ones())); check(32'(xb_pinx)); check(32'(port_pinx));
        check(32'(pc_flag)); check(32'(pc_bits));

        // Priority: source 0 OE, source 1 value on bit 0; bits 1..3 follow ddrx/portx
        rstn = 1'b1;
        port_ddrx = 8'h0E; port_portx = 8'h04;
        xb_ddoe = {8'h01, 8'h01}; xb_ddov = {8'h00, 8'h01};
        xb_pvoe = {8'h01, 8'h00}; xb_pvov = {8'h01, 8'h00};
        expect_val("prio_latency", 32'h00);
        expect_val("prio_spec", 32'h05);
        #1 check(32'(pad_ones()));
        tick(); check(32'(pad_ones()));

        xb_ddov = {8'h01, 8'h00};
        expect_val("prio_ddov_swap", 32'h04);
        tick(); check(32'(pad_ones()));

        xb_ddov = {8'h00, 8'h01};
        xb_pvoe = {8'h01, 8'h01}; xb_pvov = {8'h00, 8'h01};
        expect_val("prio_pvov_src0", 32'h05);
        tick(); check(32'(pad_ones()));

        // Mid-run reset while driving 0xFF
        xb_ddoe = '0; xb_ddov = '0; xb_pvoe = '0; xb_pvov = '0;
        port_ddrx = 8'hFF; port_portx = 8'hFF;
        expect_val("drive_ff", 32'hFF);
        tick(); check(32'(pad_ones()));
        rstn = 1'b0;
        expect_val("rst2_pads_z", 32'h00);
        expect_val("rst2_port_pinx", 32'h00);
        expect_val("rst2_pc_flag", 32'h0);
        tick(); check(32'(pad_ones())); check(32'(port_pinx)); check(32'(pc_flag));

        port_ddrx = '0; port_portx = '0;
        tb_en = 8'hFF; tb_val = 8'hA5; pcie = 1'b1; pcmsk = 8'hFF;
        expect_val("rst2_sync_held", 32'h00);
        tick(); check(32'(xb_pinx));

        // Warm-up: pads settle at 0xA5 without raising a flag
        rstn = 1'b1;
        expect_val("warm_flag_0", 32'h0);
        tick(); check(32'(pc_flag));
        expect_val("warm_flag_1", 32'h0);
        expect_val("warm_xb_pinx", 32'hA5);
        tick(); check(32'(pc_flag)); check(32'(xb_pinx));
        for (int i = 0; i < FLAT + 4; i++) begin
            expect_val("warm_flag_n", 32'h0);
            tick(); check(32'(pc_flag));
        end

        // Masked change 0x00 -> 0x11, bit 4 masked off
        pcie = 1'b0; tb_val = 8'h00;
        repeat (FLAT + 3) tick();
        pcmsk = 8'h0F; pcie = 1'b1;
        expect_val("chg_pre_flag", 32'h0);
        check(32'(pc_flag));
        tb_val = 8'h11;
        expect_val("chg_xb_1", 32'h00);
        expect_val("chg_xb_2", 32'h11);
        expect_val("chg_port_pinx", 32'h11);
        expect_val("chg_flag_early", 32'h0);
        expect_val("chg_flag", 32'h1);
        expect_val("chg_bits", 32'h01);
        tick(); check(32'(xb_pinx));
        tick(); check(32'(xb_pinx));
        repeat (FLAT - SS) tick();
        check(32'(port_pinx)); check(32'(pc_flag));
        tick(); check(32'(pc_flag)); check(32'(pc_bits));

        // Clear coinciding with a bit-2 event, then a lone clear
        tb_val = 8'h15;
        expect_val("race_bits_before", 32'h01);
        expect_val("race_flag", 32'h1);
        expect_val("race_bits", 32'h04);
        expect_val("clr_flag", 32'h0);
        expect_val("clr_bits", 32'h00);
        repeat (FLAT) tick();
        check(32'(pc_bits));
        pcint_clr = 1'b1;
        tick();
        pcint_clr = 1'b0;
        check(32'(pc_flag)); check(32'(pc_bits));
        pcint_clr = 1'b1;
        tick();
        pcint_clr = 1'b0;
        check(32'(pc_flag)); check(32'(pc_bits));

        // pcie=0 drops changes; re-enabling or widening the mask raises nothing
        pcie = 1'b0; tb_val = 8'h1D;
        expect_val("pcie0_flag", 32'h0);
        expect_val("pcie1_flag", 32'h0);
        expect_val("pcmsk_flag", 32'h0);
        repeat (FLAT + 3) tick();
        check(32'(pc_flag));
        pcie = 1'b1;
        repeat (3) tick();
        check(32'(pc_flag));
        pcmsk = 8'hFF;
        repeat (2) tick();
        check(32'(pc_flag));

        // Fresh event on bit 7 after clear
        tb_val = 8'h9D;
        expect_val("b7_flag_early", 32'h0);
        expect_val("b7_flag", 32'h1);
        expect_val("b7_bits", 32'h80);
        repeat (FLAT) tick();
        check(32'(pc_flag));
        tick(); check(32'(pc_flag)); check(32'(pc_bits));

`ifdef XLR8_PORTMUX_DEBOUNCE_EN
        // Short pulse on pad 1 is filtered; a held level passes after DB cycles
        tb_val = 8'h9F;
        expect_val("db_xb_pulse", 32'h9F);
        expect_val("db_pulse_filtered", 32'h9D);
        tick(); tick(); check(32'(xb_pinx));
        tick();
        tb_val = 8'h9D;
        repeat (8) tick();
        check(32'(port_pinx));
        tb_val = 8'h9F;
        expect_val("db_hold_early", 32'h9D);
        expect_val("db_hold", 32'h9F);
        repeat (SS + DB - 1) tick();
        check(32'(port_pinx));
        tick(); check(32'(port_pinx));
`endif

        n_checks++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
